fft_input_sequencer: RTL and testbench
======================================

FFT_INPUT_SEQUENCER -- requirements
Module: fft_input_sequencer

Interface
REQ-001 Parameter MAX_LOG2, default 12, SHALL set the largest transform size accepted (log2 of points).
REQ-002 Parameter MIN_LOG2, default 3, SHALL set the smallest transform size accepted (log2 of points).
REQ-003 Port: CLK  in  1  the single clock; all logic SHALL be rising-edge CLK.
REQ-004 Port: RSTn  in  1  reset; it SHALL be asynchronous and active-low.
REQ-005 Port: enable  in  1  when high, sequencing runs; when low, the block stops at the next frame boundary.
REQ-006 Port: frameSize  in  4  requested log2 transform size, sampled only at frame boundaries.
REQ-007 Port: value  in  16  real time-domain sample from upstream.
REQ-008 Port: valueValid  in  1  upstream sample present.
REQ-009 Port: valueReady  out  1  sample accepted this cycle.
REQ-010 Port: cfgData  out  16  FFT config word: [4:0] NFFT, [8] FWD_INV=1, all other bits 0.
REQ-011 Port: cfgValid / cfgReady  out / in  1 / 1  config channel handshake.
REQ-012 Port: tData  out  32  FFT input: [15:0] = value, [31:16] = 0 (imaginary part).
REQ-013 Port: tValid / tReady / tLast  out / in / out  1 each  FFT data handshake and frame-end marker.
REQ-014 Port: evtTlastUnexpected, evtTlastMissing  in  1 each  FFT core event pulses.
REQ-015 Port: frameDone  out  1  one-cycle pulse after the last sample of a frame transfers.
REQ-016 Port: error  out  1  sticky FFT framing error.
REQ-017 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, CONFIG and STREAM.
REQ-019 IDLE -> CONFIG when enable=1; on that transition the block SHALL latch curLog2 = clamp(frameSize, MIN_LOG2, MAX_LOG2).
REQ-020 In CONFIG, cfgValid SHALL be 1 and cfgData[4:0] SHALL equal curLog2; cfgData SHALL hold stable until cfgReady=1.
REQ-021 The CONFIG -> STREAM transition SHALL occur on the cycle with cfgValid & cfgReady, and the sample count SHALL be 0 on entry to STREAM.
REQ-022 In STREAM: tValid = valueValid, valueReady = tReady, and tData SHALL follow value combinationally with zero latency.
REQ-023 Outside STREAM, tValid, valueReady and tLast SHALL all be 0.
REQ-024 A transfer (tValid & tReady) SHALL increment the sample count; tLast SHALL be 1 only when count == 2^curLog2 - 1.
REQ-025 On the last-sample transfer, the count SHALL wrap to 0 and frameDone SHALL pulse on the next cycle.
REQ-026 At the last-sample transfer, if enable=0 the next state SHALL be IDLE.
REQ-027 At the last-sample transfer, if enable=1 and clamp(frameSize) != curLog2, the next state SHALL be CONFIG with the new size latched.
REQ-028 At the last-sample transfer, if enable=1 and the size is unchanged, the block SHALL stay in STREAM, allowing back-to-back frames with no bubble.
REQ-029 Changes to frameSize or enable in mid-frame SHALL be ignored until the frame boundary; a frame SHALL never be truncated.
REQ-030 Clamping: frameSize < MIN_LOG2 SHALL be treated as MIN_LOG2, and frameSize > MAX_LOG2 as MAX_LOG2.
REQ-031 The sample counter SHALL be MAX_LOG2 bits wide.
REQ-032 error SHALL set on any cycle with evtTlastUnexpected | evtTlastMissing and SHALL clear only on reset; sequencing SHALL continue regardless.

Reset
REQ-033 While RSTn=0: state=IDLE, count=0, curLog2=MIN_LOG2, and all outputs SHALL be 0 except cfgData, which SHALL be {7'b0, 1'b1, 3'b0, MIN_LOG2}.
REQ-034 Reset asserted mid-frame or mid-config SHALL abort immediately with no further tLast or frameDone.
REQ-035 The first enable after reset release SHALL always pass through CONFIG.

Structure
REQ-036 Shared package fft_ctrl_pkg SHALL hold: the state enum (IDLE, CONFIG, STREAM), the FWD_INV bit position (8) and the NFFT field width (5).
REQ-037 The block SHALL contain one sub-module, frame_counter (parameter width, inputs inc / clear / lastIdx, outputs count / atLast).

Verification
REQ-038 enable=1, frameSize=4, cfgReady=1, tReady=valueValid=1 -> cfgData=0x0104 for 1 cycle; 16 transfers; tLast on the 16th; frameDone 1 cycle later; the next frame starts with no gap.
REQ-039 cfgReady held 0 for 5 cycles -> cfgValid stays 1 with cfgData stable, and tValid stays 0 until the handshake completes.
REQ-040 frameSize changed 4 -> 6 at sample 7 -> the current frame still ends at 16 samples, then CONFIG with NFFT=6, then a 64-sample frame.
REQ-041 tReady toggling 1010..., frameSize=3 -> exactly 8 transfers per frame, no sample dropped or duplicated, tLast only on a transfer cycle.
REQ-042 frameSize=0 and frameSize=15 (MAX_LOG2=12) -> NFFT=3 (8 samples) and NFFT=12 (4096 samples) respectively.
REQ-043 RSTn pulsed low at sample 5; separately, enable dropped at sample 3 -> reset: outputs 0 at once, then CONFIG again after re-enable; enable drop: frame completes, then IDLE with busy=0.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT input control path: state encoding,
// config-word field layout and the transform-size clamp helper.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONFIG = 2'd1,
        STREAM = 2'd2
    } fftState_t;

    localparam int unsigned FWD_INV_BIT = 8;
    localparam int unsigned NFFT_WIDTH  = 5;

    // Limit a requested log2 size to the supported range.
    function automatic logic [NFFT_WIDTH-1:0] clampLog2(
        input logic [3:0]  req,
        input int unsigned minLog2,
        input int unsigned maxLog2
    );
        logic [NFFT_WIDTH-1:0] r;
        r = {1'b0, req};
        if (32'(req) < minLog2) begin
            r = NFFT_WIDTH'(minLog2);
        end else if (32'(req) > maxLog2) begin
            r = NFFT_WIDTH'(maxLog2);
        end
        return r;
    endfunction

    // Forward-transform config word carrying the NFFT field.
    function automatic logic [15:0] cfgWord(input logic [NFFT_WIDTH-1:0] nfft);
        logic [15:0] w;
        w = '0;
        w[FWD_INV_BIT] = 1'b1;
        w[NFFT_WIDTH-1:0] = nfft;
        return w;
    endfunction

endpackage

// File: rtl/fft_input_sequencer_frame_counter.sv
// Sample-in-frame counter: wraps to zero on the transfer of the last index.
module frame_counter #(
    parameter int unsigned width = 12
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inc,
    input  logic             clear,
    input  logic [width-1:0] lastIdx,
    output logic [width-1:0] count,
    output logic             atLast
);

    assign atLast = (count == lastIdx);

    // Count transfers; clear outside streaming, wrap at the frame end.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= atLast ? '0 : count + width'(1);
        end
    end

endmodule

// File: rtl/fft_input_sequencer.sv
// Feeds real samples into an FFT core as complex frames, issuing a config
// word whenever the transform size changes and marking each frame end.
module fft_input_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned MAX_LOG2 = 12,
    parameter int unsigned MIN_LOG2 = 3
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        enable,
    input  logic [3:0]  frameSize,
    input  logic [15:0] value,
    input  logic        valueValid,
    output logic        valueReady,
    output logic [15:0] cfgData,
    output logic        cfgValid,
    input  logic        cfgReady,
    output logic [31:0] tData,
    output logic        tValid,
    input  logic        tReady,
    output logic        tLast,
    input  logic        evtTlastUnexpected,
    input  logic        evtTlastMissing,
    output logic        frameDone,
    output logic        error,
    output logic        busy
);

    fftState_t             state;
    logic [NFFT_WIDTH-1:0] curLog2;
    logic [NFFT_WIDTH-1:0] reqLog2;
    logic [MAX_LOG2-1:0]   lastIdx;
    logic [MAX_LOG2-1:0]   sampleCount;
    logic                  atLast;
    logic                  inStream;
    logic                  xfer;
    logic                  lastXfer;

    assign reqLog2  = clampLog2(frameSize, MIN_LOG2, MAX_LOG2);
    assign lastIdx  = MAX_LOG2'((32'd1 << curLog2) - 32'd1);
    assign inStream = (state == STREAM);
    assign xfer     = inStream & valueValid & tReady;
    assign lastXfer = xfer & atLast;

    assign busy       = (state != IDLE);
    assign cfgValid   = (state == CONFIG);
    assign cfgData    = cfgWord(curLog2);
    assign tValid     = inStream & valueValid;
    assign valueReady = inStream & tReady;
    assign tData      = inStream ? {16'h0000, value} : '0;
    assign tLast      = inStream & (sampleCount == lastIdx);

    frame_counter #(
        .width(MAX_LOG2)
    ) uCounter (
        .clk    (CLK),
        .rstN   (RSTn),
        .inc    (xfer),
        .clear  (!inStream),
        .lastIdx(lastIdx),
        .count  (sampleCount),
        .atLast (atLast)
    );

    // Frame sequencing; size and enable are only acted on at frame boundaries.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            curLog2   <= NFFT_WIDTH'(MIN_LOG2);
            frameDone <= 1'b0;
            error     <= 1'b0;
        end else begin
            frameDone <= lastXfer;
            if (evtTlastUnexpected || evtTlastMissing) begin
                error <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= CONFIG;
                        curLog2 <= reqLog2;
                    end
                end
                CONFIG: begin
                    if (cfgReady) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (lastXfer) begin
                        if (!enable) begin
                            state <= IDLE;
                        end else if (reqLog2 != curLog2) begin
                            state   <= CONFIG;
                            curLog2 <= reqLog2;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_input_sequencer.sv
// Directed bench for fft_input_sequencer with a transfer scoreboard.
module tb_fft_input_sequencer;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        enable;
    logic [3:0]  frameSize;
    logic [15:0] value;
    logic        valueValid;
    logic        valueReady;
    logic [15:0] cfgData;
    logic        cfgValid;
    logic        cfgReady;
    logic [31:0] tData;
    logic        tValid;
    logic        tReady;
    logic        tLast;
    logic        evtTlastUnexpected;
    logic        evtTlastMissing;
    logic        frameDone;
    logic        error;
    logic        busy;

    int          nChecks = 0;
    int          nFails  = 0;
    logic [16:0] sbQ[$];
    bit          pendDone = 1'b0;
    bit          toggleReady = 1'b0;

    fft_input_sequencer #(
        .MAX_LOG2(12),
        .MIN_LOG2(3)
    ) dut (
        .CLK               (CLK),
        .RSTn              (RSTn),
        .enable            (enable),
        .frameSize         (frameSize),
        .value             (value),
        .valueValid        (valueValid),
        .valueReady        (valueReady),
        .cfgData           (cfgData),
        .cfgValid          (cfgValid),
        .cfgReady          (cfgReady),
        .tData             (tData),
        .tValid            (tValid),
        .tReady            (tReady),
        .tLast             (tLast),
        .evtTlastUnexpected(evtTlastUnexpected),
        .evtTlastMissing   (evtTlastMissing),
        .frameDone         (frameDone),
        .error             (error),
        .busy              (busy)
    );

    always #5 CLK = ~CLK;

    task automatic finishNow();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every transfer pops the next expected sample; frameDone
    // must follow exactly one cycle after the expected last sample.
    always @(negedge CLK) begin : monitor
        logic [16:0] e;
        check("frameDone", {31'b0, frameDone}, {31'b0, RSTn ? pendDone : 1'b0});
        pendDone = 1'b0;
        if (RSTn && tValid && tReady) begin
            nChecks++;
            assert (sbQ.size() != 0) else begin
                nFails++;
                $error("FAIL unexpectedXfer: observed tData %0h expected no transfer", tData);
            end
            if (sbQ.size() != 0) begin
                e = sbQ.pop_front();
                check("tData", tData, {16'h0000, e[15:0]});
                check("tLast", {31'b0, tLast}, {31'b0, e[16]});
                pendDone = e[16];
            end
        end
    end

    initial begin
        #2ms;
        nFails++;
        $error("FAIL watchdog: observed time limit expected completion");
        finishNow();
    end

    task automatic sendSample(input logic [15:0] v, input bit last, output int waits);
        sbQ.push_back({last, v});
        value      = v;
        valueValid = 1'b1;
        waits      = 0;
        forever begin
            @(negedge CLK);
            if (valueReady === 1'b1) break;
            waits++;
            if (waits > 100) begin
                nChecks++;
                nFails++;
                $error("FAIL sampleTimeout: observed no valueReady expected acceptance of %0h", v);
                finishNow();
            end
            @(posedge CLK); #1;
            if (toggleReady) tReady = ~tReady;
        end
        @(posedge CLK); #1;
        if (toggleReady) tReady = ~tReady;
    endtask

    task automatic sendFrame(input int n, input logic [15:0] base, input int chgAt,
                             input logic [3:0] newSize, input bit newEn, output int firstWaits);
        int w;
        firstWaits = 0;
        for (int i = 0; i < n; i++) begin
            if (i == chgAt) begin
                frameSize = newSize;
                enable    = newEn;
            end
            sendSample(16'(base + 16'(i)), (i == n - 1), w);
            if (i == 0) firstWaits = w;
        end
        valueValid = 1'b0;
    endtask

    // Expect a config word; cfgReady held low for 'hold' cycles first.
    // Upstream offers data meanwhile to prove nothing leaks through.
    task automatic doConfig(input logic [4:0] nfft, input int hold);
        int w;
        logic [15:0] expWord;
        expWord    = 16'h0100 | {11'b0, nfft};
        value      = 16'hDEAD;
        valueValid = 1'b1;
        w = 0;
        forever begin
            @(negedge CLK);
            if (cfgValid === 1'b1) break;
            w++;
            if (w > 20) begin
                nChecks++;
                nFails++;
                $error("FAIL cfgTimeout: observed no cfgValid expected config %0h", expWord);
                finishNow();
            end
        end
        check("cfgData", {16'b0, cfgData}, {16'b0, expWord});
        check("cfgTValid", {31'b0, tValid}, 32'd0);
        check("cfgBusy", {31'b0, busy}, 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            check("cfgHoldValid", {31'b0, cfgValid}, 32'd1);
            check("cfgHoldData", {16'b0, cfgData}, {16'b0, expWord});
            check("cfgHoldTValid", {31'b0, tValid}, 32'd0);
            check("cfgHoldVReady", {31'b0, valueReady}, 32'd0);
        end
        valueValid = 1'b0;
        cfgReady   = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("cfgOneCycle", {31'b0, cfgValid}, 32'd0);
        @(posedge CLK); #1;
    endtask

    initial begin
        int fw;
        RSTn               = 1'b0;
        enable             = 1'b0;
        frameSize          = 4'd4;
        value              = '0;
        valueValid         = 1'b0;
        cfgReady           = 1'b1;
        tReady             = 1'b1;
        evtTlastUnexpected = 1'b0;
        evtTlastMissing    = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rstCfgData", {16'b0, cfgData}, 32'h0103);
        check("rstCfgValid", {31'b0, cfgValid}, 32'd0);
        check("rstTValid", {31'b0, tValid}, 32'd0);
        check("rstTData", tData, 32'd0);
        check("rstTLast", {31'b0, tLast}, 32'd0);
        check("rstVReady", {31'b0, valueReady}, 32'd0);
        check("rstError", {31'b0, error}, 32'd0);
        check("rstBusy", {31'b0, busy}, 32'd0);
        @(posedge CLK); #1;
        RSTn   = 1'b1;
        enable = 1'b1;

        // 16-point frames back to back
        doConfig(5'd4, 0);
        sendFrame(16, 16'h1000, -1, 4'd4, 1'b1, fw);
        sendFrame(16, 16'h2000, -1, 4'd4, 1'b1, fw);
        check("noBubble", 32'(fw), 32'd0);

        // Size change mid-frame, stalled config, then 64 points and stop
        cfgReady = 1'b0;
        sendFrame(16, 16'h3000, 7, 4'd6, 1'b1, fw);
        doConfig(5'd6, 5);
        sendFrame(64, 16'h4000, 60, 4'd6, 1'b0, fw);
        @(negedge CLK);
        check("idleBusy", {31'b0, busy}, 32'd0);
        check("idleVReady", {31'b0, valueReady}, 32'd0);
        @(posedge CLK); #1;

        // Throttled sink, minimum size, clamping from below and above
        frameSize   = 4'd3;
        enable      = 1'b1;
        toggleReady = 1'b1;
        doConfig(5'd3, 0);
        sendFrame(8, 16'h5000, -1, 4'd3, 1'b1, fw);
        sendFrame(8, 16'h5100, 0, 4'd0, 1'b1, fw);
        sendFrame(8, 16'h5200, 2, 4'd15, 1'b1, fw);
        toggleReady = 1'b0;
        tReady      = 1'b1;
        doConfig(5'd12, 0);
        sendFrame(4096, 16'h6000, 100, 4'd15, 1'b0, fw);
        @(negedge CLK);
        check("idleBusy2", {31'b0, busy}, 32'd0);
        check("idleError", {31'b0, error}, 32'd0);

        // Sticky framing error
        @(posedge CLK); #1;
        evtTlastUnexpected = 1'b1;
        @(posedge CLK); #1;
        evtTlastUnexpected = 1'b0;
        @(negedge CLK);
        check("errorSet", {31'b0, error}, 32'd1);
        repeat (3) @(posedge CLK);
        #1;
        check("errorSticky", {31'b0, error}, 32'd1);

        // Reset mid-frame at sample 5
        frameSize = 4'd4;
        enable    = 1'b1;
        doConfig(5'd4, 0);
        for (int i = 0; i < 5; i++) begin
            sendSample(16'(16'h6800 + 16'(i)), 1'b0, fw);
        end
        value      = 16'h6805;
        valueValid = 1'b1;
        RSTn       = 1'b0;
        #1;
        check("abortTValid", {31'b0, tValid}, 32'd0);
        check("abortTLast", {31'b0, tLast}, 32'd0);
        check("abortBusy", {31'b0, busy}, 32'd0);
        check("abortCfgData", {16'b0, cfgData}, 32'h0103);
        check("abortError", {31'b0, error}, 32'd0);
        check("abortSbEmpty", 32'(sbQ.size()), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RSTn       = 1'b1;
        valueValid = 1'b0;

        // Re-enable passes through config; enable drop at sample 3
        doConfig(5'd4, 0);
        sendFrame(16, 16'h7000, 3, 4'd4, 1'b0, fw);
        @(negedge CLK);
        check("finalBusy", {31'b0, busy}, 32'd0);
        check("finalCfgValid", {31'b0, cfgValid}, 32'd0);
        check("sbDrained", 32'(sbQ.size()), 32'd0);
        repeat (2) @(posedge CLK);
        finishNow();
    end

endmodule
